// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack clock-domain crossing: holds one data word
// on a registered bus while the request/acknowledge handshake completes.
module cdc_handshake_tx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLOCK,
  input  logic              RESETN,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              xfer_req,
  output logic [DATA_W-1:0] xfer_data,
  input  logic              xfer_ack,
  output logic              busy,
  output logic              done,
  output logic [15:0]       xfer_cnt,
  output logic              proto_err
);

  typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_pipe;
  logic                   ack_sync;
  logic                   accept, ack_seen, ack_gone, ack_err;

  // Only the last flop of this chain may be looked at by any other logic.
  always_ff @(posedge CLOCK or negedge RESETN)
    if (!RESETN) ack_pipe <= '0;
    else         ack_pipe <= {ack_pipe[SYNC_STAGES-2:0], xfer_ack};

  assign ack_sync = ack_pipe[SYNC_STAGES-1];

  // A stale ack left high in IDLE must drain before a new request goes out.
  assign s_ready  = (state_q == IDLE) && !ack_sync;
  assign busy     = (state_q != IDLE);
  assign accept   = s_valid && s_ready;
  assign ack_seen = (state_q == REQ_HI) && ack_sync;
  assign ack_gone = (state_q == REQ_LO) && !ack_sync;
  assign ack_err  = (state_q == IDLE) && ack_sync;

  always_ff @(posedge CLOCK or negedge RESETN)
    if (!RESETN) state_q <= IDLE;
    else         state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)   state_d = REQ_HI;
      REQ_HI:  if (ack_seen) state_d = REQ_LO;
      REQ_LO:  if (ack_gone) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // xfer_req comes straight off a flop so the far domain never sees a glitch.
  always_ff @(posedge CLOCK or negedge RESETN)
    if (!RESETN) begin
      xfer_req  <= 1'b0;
      xfer_data <= '0;
      done      <= 1'b0;
      xfer_cnt  <= 16'h0000;
      proto_err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        xfer_req  <= 1'b1;
        xfer_data <= s_data;
      end
      if (ack_seen) xfer_req <= 1'b0;
      if (ack_gone) begin
        done     <= 1'b1;
        xfer_cnt <= xfer_cnt + 16'd1;
      end
      if (ack_err) proto_err <= 1'b1;
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx (DATA_W=8, SYNC_STAGES=2); the bench
// plays the destination side with fixed, hand-timed acknowledge edges.
module tb_cdc_handshake_tx;

  logic        CLOCK = 1'b0;
  logic        RESETN = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready;
  logic        xfer_req;
  logic [7:0]  xfer_data;
  logic        xfer_ack = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] xfer_cnt;
  logic        proto_err;

  int n_chk  = 0;
  int n_pass = 0;

  cdc_handshake_tx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .CLOCK(CLOCK), .RESETN(RESETN),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .xfer_req(xfer_req), .xfer_data(xfer_data), .xfer_ack(xfer_ack),
    .busy(busy), .done(done), .xfer_cnt(xfer_cnt), .proto_err(proto_err)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic step(input int n = 1);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    RESETN   = 1'b0;
    xfer_ack = 1'b0;
    s_valid  = 1'b0;
    step(2);
    RESETN = 1'b1;
  endtask

  // Called on the falling edge right after an accept; acknowledge goes high
  // immediately, then low as soon as the request is seen to drop.
  task automatic handshake(input string tag, input logic [7:0] d, input logic [15:0] cnt_exp);
    xfer_ack = 1'b1;
    step(1); chk({tag, ".req_e1"}, xfer_req, 1);
    step(1); chk({tag, ".req_e2"}, xfer_req, 1);
             chk({tag, ".data_hold1"}, xfer_data, d);
    step(1); chk({tag, ".req_fall"}, xfer_req, 0);
             chk({tag, ".busy_lo"}, busy, 1);
    xfer_ack = 1'b0;
    step(2); chk({tag, ".done_early"}, done, 0);
             chk({tag, ".data_hold2"}, xfer_data, d);
    step(1); chk({tag, ".done"}, done, 1);
             chk({tag, ".cnt"}, xfer_cnt, cnt_exp);
             chk({tag, ".idle"}, busy, 0);
  endtask

  initial begin
    // Reset state
    step(1);
    chk("rst.req", xfer_req, 0);
    chk("rst.data", xfer_data, 8'h00);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.cnt", xfer_cnt, 16'h0000);
    chk("rst.perr", proto_err, 0);
    step(1);
    RESETN = 1'b1;
    chk("rst.ready", s_ready, 1);

    // Single transfer of 0xA5
    s_valid = 1'b1; s_data = 8'hA5;
    step(1);
    s_valid = 1'b0; s_data = 8'h00;
    chk("t1.req", xfer_req, 1);
    chk("t1.data", xfer_data, 8'hA5);
    chk("t1.busy", busy, 1);
    chk("t1.ready", s_ready, 0);
    handshake("t1", 8'hA5, 16'd1);
    step(1);
    chk("t1.done_once", done, 0);
    chk("t1.cnt_hold", xfer_cnt, 16'd1);

    // Ignored request while busy, then back-to-back accept on the done cycle
    do_reset();
    s_valid = 1'b1; s_data = 8'h11;
    step(1);
    s_data = 8'h22;
    chk("b2b.first", xfer_data, 8'h11);
    handshake("b2b1", 8'h11, 16'd1);
    chk("b2b.ready_on_done", s_ready, 1);
    chk("b2b.data_on_done", xfer_data, 8'h11);
    step(1);
    s_valid = 1'b0;
    chk("b2b.second", xfer_data, 8'h22);
    chk("b2b.req2", xfer_req, 1);
    chk("b2b.done_drop", done, 0);
    handshake("b2b2", 8'h22, 16'd2);
    step(2);
    chk("b2b.no_third", busy, 0);
    chk("b2b.cnt_final", xfer_cnt, 16'd2);

    // Stray acknowledge in IDLE
    do_reset();
    xfer_ack = 1'b1;
    step(1);
    chk("perr.pre", proto_err, 0);
    step(1);
    chk("perr.ready_lo", s_ready, 0);
    s_valid = 1'b1; s_data = 8'h5A;
    step(1);
    chk("perr.set", proto_err, 1);
    chk("perr.no_req", xfer_req, 0);
    step(1);
    xfer_ack = 1'b0;
    step(1);
    chk("perr.ready_still_lo", s_ready, 0);
    chk("perr.idle", busy, 0);
    step(1);
    s_valid = 1'b0;
    chk("perr.ready_back", s_ready, 1);
    step(1);
    chk("perr.no_xfer", xfer_req, 0);
    chk("perr.data", xfer_data, 8'h00);
    chk("perr.sticky", proto_err, 1);

    // Reset in the middle of REQ_HI
    do_reset();
    chk("mid.perr_clr", proto_err, 0);
    s_valid = 1'b1; s_data = 8'h3C;
    step(1);
    s_valid = 1'b0;
    xfer_ack = 1'b1;
    step(1);
    chk("mid.req_hi", xfer_req, 1);
    #2 RESETN = 1'b0;
    #1;
    chk("mid.req_async", xfer_req, 0);
    chk("mid.busy", busy, 0);
    chk("mid.cnt", xfer_cnt, 16'd0);
    xfer_ack = 1'b0;
    step(2);
    RESETN = 1'b1;
    chk("mid.ready", s_ready, 1);
    step(1);
    chk("mid.no_done", done, 0);
    chk("mid.cnt2", xfer_cnt, 16'd0);

    // Counter wrap from 0xFFFF
    do_reset();
    force dut.xfer_cnt = 16'hFFFF;
    step(1);
    release dut.xfer_cnt;
    step(1);
    chk("wrap.preload", xfer_cnt, 16'hFFFF);
    s_valid = 1'b1; s_data = 8'h77;
    step(1);
    s_valid = 1'b0;
    chk("wrap.data", xfer_data, 8'h77);
    handshake("wrap", 8'h77, 16'h0000);
    chk("wrap.no_err", proto_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
